arb_rr: RTL and testbench

- Registered round-robin arbiter built on the priority-to-one-hot converter. It picks one of WIDTH requesters and presents the winner as a one-hot grant plus a binary index on a valid/ready handshake.
- Fairness comes from a rotating mask register: search starts just above the last served requester.
- Sits upstream of shared-resource muxes; its one-hot grant drives their select lines directly.

---
 rtl/arb_pkg.sv | 42 ++++
 rtl/pry2oht.sv | 65 ++++++
 rtl/arb_rr.sv | 113 +++++++++++
 tb/tb_arb_rr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM states and one-hot helper functions
// used by arb_rr and the other arbiters in this library.
package arb_pkg;

  // Helper functions work on a fixed maximum width; callers zero-extend
  // their vectors on the way in and truncate the result on the way out.
  localparam int unsigned ARB_MAX_W   = 64;
  localparam int unsigned ARB_MAX_LOG = 6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot to binary: ORs together the indices of all set bits, which
  // is the exact index for a one-hot input and 0 for an all-zero input.
  function automatic logic [ARB_MAX_LOG-1:0] oht2bin(input logic [ARB_MAX_W-1:0] oht);
    logic [ARB_MAX_LOG-1:0] bin;
    bin = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      if (oht[i]) begin
        bin = bin | ARB_MAX_LOG'(i);
      end
    end
    return bin;
  endfunction

  // Bits strictly above the set bit of a one-hot vector; all-zero input
  // gives all-zero output.
  function automatic logic [ARB_MAX_W-1:0] msk_above(input logic [ARB_MAX_W-1:0] oht);
    logic [ARB_MAX_W-1:0] res;
    logic                 seen;
    res  = '0;
    seen = 1'b0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      res[i] = seen;
      seen   = seen | oht[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/pry2oht.sv
// Priority-to-one-hot converter: keeps only the highest-priority set bit
// of req. DIRECTION "LSB" gives bit 0 top priority, "MSB" gives bit
// WIDTH-1 top priority. IMPLEMENTATION 0 is a two-level grouped search
// with SPLIT bits per group; any other value uses the borrow trick.
module pry2oht #(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0,
  parameter     DIRECTION      = "LSB"
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht
);

  logic [WIDTH-1:0] reqOrd;
  logic [WIDTH-1:0] ohtOrd;

  // Flip bit order for MSB priority so the core search is always LSB-first.
  if (DIRECTION == "MSB") begin : g_rev
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      assign reqOrd[k] = req[WIDTH-1-k];
      assign oht[k]    = ohtOrd[WIDTH-1-k];
    end
  end else begin : g_fwd
    assign reqOrd = req;
    assign oht    = ohtOrd;
  end

  if (IMPLEMENTATION == 0) begin : g_tree
    localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;

    logic [NGRP-1:0] grpAny;
    logic [NGRP-1:0] grpSel;
    logic            grpFound;
    logic            bitFound;

    // First find the lowest group with any request, then the lowest bit in it.
    always_comb begin
      grpAny = '0;
      for (int i = 0; i < WIDTH; i++) begin
        grpAny[i/SPLIT] = grpAny[i/SPLIT] | reqOrd[i];
      end
      grpSel   = '0;
      grpFound = 1'b0;
      for (int g = 0; g < NGRP; g++) begin
        if (!grpFound && grpAny[g]) begin
          grpSel[g] = 1'b1;
          grpFound  = 1'b1;
        end
      end
      ohtOrd   = '0;
      bitFound = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!bitFound && grpSel[i/SPLIT] && reqOrd[i]) begin
          ohtOrd[i] = 1'b1;
          bitFound  = 1'b1;
        end
      end
    end
  end else begin : g_arith
    // x & -x isolates the lowest set bit.
    assign ohtOrd = reqOrd & (~reqOrd + WIDTH'(1));
  end

endmodule

// File: rtl/arb_rr.sv
// Registered round-robin arbiter. A rotating mask makes the search start
// just above the last served requester; the winner is presented as a
// one-hot grant plus binary index on a valid/ready handshake.
module arb_rr
  import arb_pkg::*;
#(
  parameter  int WIDTH          = 8,
  parameter  int SPLIT          = 2,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  input  logic                 lck,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 vld,
  input  logic                 rdy
);

  arb_state_e           state_q;
  logic [WIDTH-1:0]     msk_q;
  logic [WIDTH-1:0]     gnt_q;
  logic [WIDTH_LOG-1:0] idx_q;
  logic                 vld_q;

  logic [WIDTH-1:0]     mskAboveGnt;
  logic [WIDTH-1:0]     arbMsk;
  logic [WIDTH-1:0]     mreq;
  logic [WIDTH-1:0]     winMsk;
  logic [WIDTH-1:0]     winAll;
  logic [WIDTH-1:0]     win;
  logic [WIDTH_LOG-1:0] winIdx;

  // While busy, the only arbitration that matters happens on a transfer,
  // and it must already use the mask for the grant being released.
  assign mskAboveGnt = WIDTH'(msk_above(ARB_MAX_W'(gnt_q)));
  assign arbMsk      = (state_q == BUSY) ? mskAboveGnt : msk_q;
  assign mreq        = req & arbMsk;

  pry2oht #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION),
    .DIRECTION      ("LSB")
  ) u_pry_msk (
    .req (mreq),
    .oht (winMsk)
  );

  pry2oht #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION),
    .DIRECTION      ("LSB")
  ) u_pry_all (
    .req (req),
    .oht (winAll)
  );

  // Nothing left above the mask: wrap around to the lowest active requester.
  assign win    = (|mreq) ? winMsk : winAll;
  assign winIdx = WIDTH_LOG'(oht2bin(ARB_MAX_W'(win)));

  // Grant FSM: load a winner from IDLE, hold it until a transfer, then
  // either keep it (locked) or rotate the mask and re-arbitrate at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      msk_q   <= '1;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= win;
            idx_q   <= winIdx;
            vld_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (rdy && !lck) begin
            msk_q <= mskAboveGnt;
            if (|req) begin
              gnt_q <= win;
              idx_q <= winIdx;
            end else begin
              gnt_q   <= '0;
              idx_q   <= '0;
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          idx_q   <= '0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt = gnt_q;
  assign idx = idx_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_arb_rr.sv
// Self-checking bench for arb_rr: a round-robin model tracks which
// requester was served last and picks the next one by plain index search;
// directed scenarios pin the model with hand-computed grants.
module tb_arb_rr;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] req;
  logic         lck;
  logic         rdy;
  logic [W-1:0] gnt;
  logic [2:0]   idx;
  logic         vld;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  // Model: whether a grant is up, who holds it, who was served last (-1 = none).
  bit mVld;
  int mIdx;
  int mLast;

  arb_rr #(
    .WIDTH          (W),
    .SPLIT          (2),
    .IMPLEMENTATION (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lck   (lck),
    .gnt   (gnt),
    .idx   (idx),
    .vld   (vld),
    .rdy   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First active requester strictly after 'last', wrapping to the lowest one.
  function automatic int pickWinner(input logic [W-1:0] r, input int last);
    for (int i = last + 1; i < W; i++) begin
      if (r[i]) return i;
    end
    for (int i = 0; i < W; i++) begin
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // Model update on the same clock edge the DUT uses.
  always @(posedge clk) begin
    if (!rst_n) begin
      mVld  <= 1'b0;
      mIdx  <= 0;
      mLast <= -1;
    end else if (!mVld) begin
      if (req != '0) begin
        mVld <= 1'b1;
        mIdx <= pickWinner(req, mLast);
      end
    end else if (rdy && !lck) begin
      mLast <= mIdx;
      if (req != '0) begin
        mIdx <= pickWinner(req, mIdx);
      end else begin
        mVld <= 1'b0;
        mIdx <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("vld", 32'(vld), 32'(mVld));
      checkOutput("gnt", 32'(gnt), mVld ? (32'd1 << mIdx) : 32'd0);
      checkOutput("idx", 32'(idx), mVld ? 32'(mIdx) : 32'd0);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] r, input logic rd, input logic l);
    req = r;
    rdy = rd;
    lck = l;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOn = 1'b1;
    rst_n   = 1'b1;

    $display("[TB] idle with no requests");
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checkOutput("idle_vld", 32'(vld), 32'd0);
      checkOutput("idle_gnt", 32'(gnt), 32'd0);
    end

    $display("[TB] full rotation with all requesters active");
    applyStimulus(8'hFF, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      nextCycle();
      checkOutput("rot_gnt", 32'(gnt), 32'd1 << (k % 8));
      checkOutput("rot_idx", 32'(idx), 32'(k % 8));
    end

    $display("[TB] grant held under backpressure");
    resetDut();
    applyStimulus(8'h14, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("hold_gnt", 32'(gnt), 32'h04);
    end
    applyStimulus(8'h00, 1'b0, 1'b0);
    nextCycle();
    checkOutput("drop_gnt", 32'(gnt), 32'h04);
    checkOutput("drop_vld", 32'(vld), 32'd1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    nextCycle();
    checkOutput("after_xfer_vld", 32'(vld), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    nextCycle();

    $display("[TB] wrap from top requester");
    resetDut();
    applyStimulus(8'h80, 1'b0, 1'b0);
    nextCycle();
    checkOutput("wrap_first", 32'(gnt), 32'h80);
    applyStimulus(8'h81, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checkOutput("wrap_alt", 32'(gnt), (k % 2 == 0) ? 32'h01 : 32'h80);
    end

    $display("[TB] locked multi-beat packet");
    resetDut();
    applyStimulus(8'h04, 1'b0, 1'b0);
    nextCycle();
    checkOutput("lock_start", 32'(gnt), 32'h04);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("lock_hold", 32'(gnt), 32'h04);
    end
    applyStimulus(8'hFF, 1'b1, 1'b0);
    nextCycle();
    checkOutput("lock_release", 32'(gnt), 32'h08);
    checkOutput("lock_release_idx", 32'(idx), 32'd3);

    $display("[TB] reset while a grant is pending");
    resetDut();
    applyStimulus(8'h10, 1'b0, 1'b0);
    nextCycle();
    checkOutput("pend_gnt", 32'(gnt), 32'h10);
    rst_n = 1'b0;
    nextCycle();
    checkOutput("rst_vld", 32'(vld), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1'b1, 1'b0);
    nextCycle();
    checkOutput("post_rst_gnt", 32'(gnt), 32'h01);

    $display("[TB] mixed traffic against the model");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(W'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      nextCycle();
    end
    applyStimulus(8'h00, 1'b1, 1'b0);
    nextCycle();
    nextCycle();

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
